// File: rtl/seq_div32_pkg.sv
// Shared definitions for the seq_div32 sequential divider: FSM state
// encoding, default operand width and iteration-counter sizing.
package seq_div32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;

    // Down-counter must hold WIDTH-1 down to terminal count 0.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_div32_div_step.sv
// One restoring shift-subtract iteration. The shifted partial remainder
// is compared against the divisor with a WIDTH+1-bit subtractor; on no
// borrow the difference is kept and the quotient bit is 1.
module div_step
    import seq_div32_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic             borrow;
    logic             diff_top_unused;
    logic [WIDTH-1:0] diff_lo;

    // The top difference bit is always 0 when there is no borrow, since
    // the kept remainder stays below the divisor.
    assign {borrow, diff_top_unused, diff_lo} = {1'b0, partial} - {2'b00, divisor};

    assign q_bit    = ~borrow;
    assign rem_next = borrow ? partial[WIDTH-1:0] : diff_lo;

endmodule

// File: rtl/seq_div32.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Build option: define SEQ_DIV32_SIGNED_EN to honour signed_op
// (truncating two's-complement division with overflow detection);
// otherwise every operation is unsigned and overflow stays 0.
//
// state | meaning
// IDLE  | waiting for start; operands and mode captured here
// RUN   | WIDTH shift-subtract iterations, down-counter to 0
// DONE  | one cycle, done pulse, results already registered
module seq_div32
    import seq_div32_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             is_ovf;

    // quo_q starts as the dividend magnitude and is shifted out MSB first
    // while quotient bits are shifted in at the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .partial  ({rem_q, quo_q[WIDTH-1]}),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    assign q_next = {quo_q[WIDTH-2:0], step_bit};

`ifdef SEQ_DIV32_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Capture result signs at start: quotient negative when signs differ,
    // remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op & dividend[WIDTH-1];
        end
    end

    assign dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign q_res   = neg_q ? -q_next   : q_next;
    assign r_res   = neg_r ? -step_rem : step_rem;
    assign is_ovf  = signed_op && (dividend == MOST_NEG) && (divisor == '1);
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_res   = q_next;
    assign r_res   = step_rem;
    assign is_ovf  = 1'b0;
`endif

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            overflow  <= 1'b0;
                        end else if (is_ovf) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= dividend;
                            remainder <= '0;
                            div_zero  <= 1'b0;
                            overflow  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            rem_q  <= '0;
                            quo_q  <= dvd_mag;
                            dvsr_q <= dvs_mag;
                            cnt    <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    rem_q <= step_rem;
                    quo_q <= q_next;
                    if (cnt == '0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= q_res;
                        remainder <= r_res;
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div32.sv
// Directed self-checking bench for seq_div32 (WIDTH = 32).
module tb_seq_div32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic        overflow;

    int vectors;
    int miscompares;
    int done_cnt;

    seq_div32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one division and check latency and all result fields.
    task automatic do_div(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input logic eov, input int elat);
        int lat;
        @(negedge clk);
        start = 1'b1; signed_op = sgn; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
        check({tag, " overflow"}, 32'(overflow), 32'(eov));
        check({tag, " busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " quotient_hold"}, quotient, eq);
    endtask

    initial begin
        int d0;
        vectors = 0; miscompares = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset flags", {30'd0, div_zero, overflow}, 32'd0);
        @(negedge clk); rst = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);
        do_div("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 1'b0, 33);
        do_div("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 1);
        do_div("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 1);
        do_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 33);
        do_div("u_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 33);
        do_div("u0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 33);
        do_div("u3_9", 1'b0, 32'd3, 32'd9, 32'd0, 32'd3, 1'b0, 1'b0, 33);
`ifdef SEQ_DIV32_SIGNED_EN
        do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        do_div("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 33);
        do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 1);
`else
        do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 1'b0, 33);
        do_div("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFF9, 1'b0, 1'b0, 33);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd7, 1'b0, 1'b0, 33);
        do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0, 33);
`endif
        do_div("u100_7_again", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);

        // Reset 10 cycles into RUN: outputs cleared, no done from aborted op.
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        check("midrun_rst busy", 32'(busy), 32'd0);
        check("midrun_rst quotient", quotient, 32'd0);
        check("midrun_rst remainder", remainder, 32'd0);
        check("midrun_rst flags", {30'd0, div_zero, overflow}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrun_rst no_done", 32'(done_cnt - d0), 32'd0);
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33);

        // Start in the same cycle as reset is ignored.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 32'd5; divisor = 32'd0;
        d0 = done_cnt;
        @(posedge clk); #1;
        check("rst_start busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_start div_zero", 32'(div_zero), 32'd0);

        // Second start during RUN is dropped; only one done.
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd0;
        @(negedge clk); start = 1'b0;
        repeat (60) @(negedge clk);
        check("busy_start done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_start quotient", quotient, 32'd100);
        check("busy_start remainder", remainder, 32'd0);
        check("busy_start div_zero", 32'(div_zero), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_div32.md
SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port signed_op, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have port dividend, input, WIDTH, numerator; sampled with start.
REQ-007 The block SHALL have port divisor, input, WIDTH, denominator; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high in RUN and DONE states.
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse marking valid results.
REQ-010 The block SHALL have port quotient, output, WIDTH, quotient result.
REQ-011 The block SHALL have port remainder, output, WIDTH, remainder result.
REQ-012 The block SHALL have port div_zero, output, 1, divisor was zero; valid with done.
REQ-013 The block SHALL have port overflow, output, 1, signed overflow (most-negative / -1); valid with done.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE after WIDTH iterations; DONE -> IDLE unconditionally after one cycle.
REQ-015 Algorithm SHALL be restoring shift-subtract, one quotient bit per RUN cycle, MSB first, using a WIDTH+1-bit subtractor: partial remainder minus divisor, keep difference and set bit when no borrow.
REQ-016 Latency: start high in IDLE at edge N, done high in cycle N+WIDTH+1 (N+33 for WIDTH=32).
REQ-017 quotient, remainder, div_zero, overflow SHALL update only on entry to DONE and hold until the next accepted start's DONE.
REQ-018 start while busy SHALL be ignored; no queuing.
REQ-019 Divisor zero: RUN skipped, IDLE -> DONE directly (done at N+1); quotient = all ones, remainder = dividend, div_zero = 1.
REQ-020 Signed mode: operands converted to magnitudes at start; quotient negated when operand signs differ; remainder takes dividend's sign (truncating division).
REQ-021 Signed dividend = 1 followed by WIDTH-1 zeros with divisor = all ones: RUN skipped, done at N+1; quotient = dividend, remainder = 0, overflow = 1.
REQ-022 div_zero and overflow SHALL be 0 for all other results; both are never set together.

Reset
REQ-023 rst high at an edge SHALL force IDLE and clear busy, done, quotient, remainder, div_zero, overflow to 0, including mid-RUN; the aborted operation produces no done.
REQ-024 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-025 Macro SEQ_DIV32_SIGNED_EN defined: signed_op honoured per REQ-020/021.
REQ-026 Macro SEQ_DIV32_SIGNED_EN undefined: signed_op ignored, all operations unsigned, overflow tied 0, negation logic absent.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE), the default WIDTH constant and the iteration counter width (log2 WIDTH + 1).
REQ-028 One sub-module div_step SHALL implement a single combinational shift-subtract iteration (partial remainder, divisor in; next remainder, quotient bit out); seq_div32 instantiates it once.

Verification
REQ-029 Unsigned 100 / 7 -> quotient 14, remainder 2, done exactly 33 cycles after start, flags 0.
REQ-030 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned same operands -> quotient 0x7FFFFFFC, remainder 1.
REQ-031 5 / 0 -> done next cycle, quotient 0xFFFFFFFF, remainder 5, div_zero 1.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> done next cycle, quotient 0x80000000, remainder 0, overflow 1 (0 with macro undefined, giving quotient 0, remainder 0x80000000 after 33 cycles).
REQ-033 rst pulsed 10 cycles into RUN -> all outputs 0 next cycle, no done; fresh 9 / 3 then gives quotient 3, remainder 0.
REQ-034 Second start pulsed during RUN of 1000 / 10 -> ignored, single done with quotient 100, remainder 0.
